// File: rtl/mont_pkg.sv
// Shared definitions for the bit-serial Montgomery multiplier:
// FSM state encoding, default operand width and counter sizing.
package mont_pkg;

    localparam int DEFAULT_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOP = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Width of the iteration counter that indexes operand a bit by bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration, purely combinational:
//   s = r + (bit ? b : 0); if s odd, s += n; r_o = s >> 1.
// The WIDTH+2 bit accumulator holds r < 2N plus b plus N without overflow.
module mont_step import mont_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH+1:0] r_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH+1:0] r_o
);

    logic [WIDTH+1:0] sum_ab;
    logic [WIDTH+1:0] sum_abn;

    // Conditional add of b, then add N when needed to make the sum even.
    always_comb begin
        sum_ab  = r_i + (bit_i ? {2'b00, b_i} : '0);
        sum_abn = sum_ab[0] ? (sum_ab + {2'b00, n_i}) : sum_ab;
        r_o     = {1'b0, sum_abn[WIDTH+1:1]};
    end

endmodule

// File: rtl/montgomery_mul.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod N.
// One operand set per input handshake, WIDTH LOOP cycles plus one SUB cycle,
// result held on a valid/ready output until accepted.
// Optional build macro: MONTGOMERY_CHECK_EN enables simulation assertions on
// operand legality and output stability; datapath behaviour is unchanged.
module montgomery_mul import mont_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_result
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH+1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH+1:0] r_step;
    logic             r_ge_n;
    logic [WIDTH-1:0] r_minus_n;

    mont_step #(.WIDTH(WIDTH)) u_step (
        .r_i   (r_q),
        .bit_i (a_q[cnt_q]),
        .b_i   (b_q),
        .n_i   (n_q),
        .r_o   (r_step)
    );

    // Final conditional subtraction; R < 2N so R - N fits in WIDTH bits.
    assign r_ge_n    = (r_q >= {2'b00, n_q});
    assign r_minus_n = WIDTH'(r_q - {2'b00, n_q});

    assign i_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_result = result_q;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next-value logic.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    n_d     = i_n;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = LOOP;
                end
            end
            LOOP: begin
                r_d   = r_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                result_d = r_ge_n ? r_minus_n : r_q[WIDTH-1:0];
                state_d  = DONE;
            end
            DONE: begin
                if (o_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: operands, accumulator, counter and held result.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are plain registers rather than a memory array, so they
        // are reset to give well-defined outputs after an abort.
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

`ifdef MONTGOMERY_CHECK_EN
    // Operand legality at capture: N odd, a < N, b < N.
    a_operands_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (i_valid && i_ready) |-> (i_n[0] && (i_a < i_n) && (i_b < i_n)));

    // A presented result is always fully reduced.
    a_result_reduced: assert property (@(posedge clk) disable iff (!rst_n)
        o_valid |-> (o_result < n_q));

    // Output held stable while stalled by the consumer.
    a_output_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (o_valid && !o_ready) |=> (o_valid && $stable(o_result)));
`else
`endif

endmodule
